// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the stall/flush sequencer: Tuse/Tnew values, mult/div
// busy states and the CP0 EPC register number.
package hazard_stall_ctrl_pkg;

    typedef logic [1:0] tval_t;

    localparam tval_t T0     = 2'd0;
    localparam tval_t T1     = 2'd1;
    localparam tval_t T2     = 2'd2;
    localparam tval_t T_NONE = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

    localparam logic [4:0] CP0_EPC  = 5'd14;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // A producer blocks a consumer when its result arrives later than the
    // consumer needs it; T_NONE (3) can never be exceeded by a 0..2 Tnew.
    function automatic logic raw_hazard(input logic [4:0] src,
                                        input tval_t      tuse,
                                        input logic [4:0] a3,
                                        input tval_t      tnew);
        return (src == a3) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div occupancy tracker: counts down the HI/LO busy window after an
// issue from E and reports md_busy as a registered flag.
import hazard_stall_ctrl_pkg::*;

module md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic req,
    output logic md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             md_busy_q, md_busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            md_busy_q <= md_busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        // A start coincident with req is dropped: that instruction is being
        // flushed. An in-flight count is left alone so HI/LO still completes.
        if (start && !req) begin
            if (is_div) begin
                state_d = MD_DIV;
                count_d = CNT_W'(DIV_CYC);
            end else begin
                state_d = MD_MULT;
                count_d = CNT_W'(MULT_CYC);
            end
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
            if (count_d == '0) begin
                state_d = MD_IDLE;
            end
        end
        md_busy_d = (count_d != '0);
    end

    assign md_busy = md_busy_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combines data, mult/div and
// EPC-before-ERET hazards into PC/IF_ID enables and the ID_EX bubble.
import hazard_stall_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [1:0]  tuse_rs_d,
    input  logic [1:0]  tuse_rt_d,
    input  logic [4:0]  a3_e,
    input  logic [4:0]  a3_m,
    input  logic [1:0]  tnew_e,
    input  logic [1:0]  tnew_m,
    input  logic        md_use_d,
    input  logic        md_start_e,
    input  logic        md_div_e,
    input  logic        eret_d,
    input  logic        mtc0_epc_e,
    input  logic        mtc0_epc_m,
    input  logic        req,
    output logic        pc_en,
    output logic        fd_en,
    output logic        id_ex_clr,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    logic        stall_rs, stall_rt, stall_md, stall_eret, stall;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start_e),
        .is_div  (md_div_e),
        .req     (req),
        .md_busy (md_busy)
    );

    always_comb begin
        stall_rs   = (rs_d != REG_ZERO) &&
                     (raw_hazard(rs_d, tuse_rs_d, a3_e, tnew_e) ||
                      raw_hazard(rs_d, tuse_rs_d, a3_m, tnew_m));
        stall_rt   = (rt_d != REG_ZERO) &&
                     (raw_hazard(rt_d, tuse_rt_d, a3_e, tnew_e) ||
                      raw_hazard(rt_d, tuse_rt_d, a3_m, tnew_m));
        stall_md   = md_use_d && (md_start_e || md_busy);
        stall_eret = eret_d && (mtc0_epc_e || mtc0_epc_m);
        stall      = stall_rs | stall_rt | stall_md | stall_eret;

        // On req the pipeline registers flush themselves; a bubble here would
        // overwrite the exception vector PC carried through ID_EX.
        if (reset || req) begin
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            id_ex_clr = 1'b0;
        end else begin
            pc_en     = ~stall;
            fd_en     = ~stall;
            id_ex_clr = stall;
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && !req) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each scenario task drives one cycle
// at a time, queues the expected outputs and checks them at the falling edge.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, a3_e, a3_m;
    logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic        md_use_d, md_start_e, md_div_e, eret_d;
    logic        mtc0_epc_e, mtc0_epc_m, req;
    logic        pc_en, fd_en, id_ex_clr, md_busy;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic        pc;
        logic        fd;
        logic        clr;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_sc   = 32'd0;

    hazard_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .tuse_rs_d    (tuse_rs_d),
        .tuse_rt_d    (tuse_rt_d),
        .a3_e         (a3_e),
        .a3_m         (a3_m),
        .tnew_e       (tnew_e),
        .tnew_m       (tnew_m),
        .md_use_d     (md_use_d),
        .md_start_e   (md_start_e),
        .md_div_e     (md_div_e),
        .eret_d       (eret_d),
        .mtc0_epc_e   (mtc0_epc_e),
        .mtc0_epc_m   (mtc0_epc_m),
        .req          (req),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .id_ex_clr    (id_ex_clr),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        rs_d = 5'd0; rt_d = 5'd0; a3_e = 5'd0; a3_m = 5'd0;
        tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_e = 2'd0; tnew_m = 2'd0;
        md_use_d = 1'b0; md_start_e = 1'b0; md_div_e = 1'b0; eret_d = 1'b0;
        mtc0_epc_e = 1'b0; mtc0_epc_m = 1'b0; req = 1'b0;
    endtask

    // Queue the expected outputs for the cycle just driven; stall=1 means a
    // bubble with frozen PC/IF_ID.
    task automatic push_exp(input logic st, input logic busy);
        exp_t e;
        e.pc   = !st;
        e.fd   = !st;
        e.clr  = st;
        e.busy = busy;
        e.sc   = exp_sc;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        reset = 1'b1;
        // Hazards present while reset is held must neither stall nor count.
        rs_d = 5'd3; tuse_rs_d = 2'd0; a3_e = 5'd3; tnew_e = 2'd2; md_use_d = 1'b1; md_start_e = 1'b1;
        for (int c = 0; c < 3; c++) begin
            push_exp(1'b0, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL reset cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            next_cycle();
        end
        idle_inputs();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_raw_hazard();
        exp_t e;
        logic st;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin rs_d = 5'd1; tuse_rs_d = 2'd1; a3_e = 5'd1; tnew_e = 2'd2; st = 1'b1; end
                1: begin rs_d = 5'd1; tuse_rs_d = 2'd1; a3_m = 5'd1; tnew_m = 2'd1; st = 1'b0; end
                2: begin rt_d = 5'd5; tuse_rt_d = 2'd0; a3_m = 5'd5; tnew_m = 2'd1; st = 1'b1; end
                3: begin rt_d = 5'd5; tuse_rt_d = 2'd3; a3_e = 5'd5; tnew_e = 2'd2; st = 1'b0; end
                default: begin rs_d = 5'd7; tuse_rs_d = 2'd2; a3_e = 5'd7; tnew_e = 2'd2; st = 1'b0; end
            endcase
            push_exp(st, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL raw_hazard cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_zero_reg();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            if (c == 0) begin rs_d = 5'd0; tuse_rs_d = 2'd0; a3_e = 5'd0; tnew_e = 2'd2; end
            else        begin rt_d = 5'd0; tuse_rt_d = 2'd0; a3_m = 5'd0; tnew_m = 2'd1; end
            push_exp(1'b0, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL zero_reg cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_div_stall();
        exp_t e;
        // Issue cycle plus ten busy cycles stall; the twelfth cycle proceeds.
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            md_use_d = 1'b1;
            if (c == 0) begin md_start_e = 1'b1; md_div_e = 1'b1; end
            push_exp(c < 11, (c >= 1) && (c <= 10));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL div_stall cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_mult_req();
        exp_t e;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            case (c)
                0: begin md_start_e = 1'b1; md_use_d = 1'b1; push_exp(1'b1, 1'b0); end
                2: begin req = 1'b1; md_use_d = 1'b1; push_exp(1'b0, 1'b1); end
                1, 3, 4, 5: begin md_use_d = 1'b1; push_exp(1'b1, 1'b1); end
                6: begin md_use_d = 1'b1; push_exp(1'b0, 1'b0); end
                7: begin md_start_e = 1'b1; req = 1'b1; push_exp(1'b0, 1'b0); end
                default: push_exp(1'b0, 1'b0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL mult_req cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_eret();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            eret_d = 1'b1;
            if (c == 0) mtc0_epc_e = 1'b1;
            if (c == 1) mtc0_epc_m = 1'b1;
            push_exp(c < 2, 1'b0);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL eret cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // mult then div one cycle later: the div reload wins, busy for 10 more.
        for (int c = 0; c < 13; c++) begin
            idle_inputs();
            if (c == 0) md_start_e = 1'b1;
            if (c == 1) begin md_start_e = 1'b1; md_div_e = 1'b1; end
            if (c == 12) md_use_d = 1'b1;
            push_exp(1'b0, (c >= 1) && (c <= 11));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr) exp_sc++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) begin md_start_e = 1'b1; md_use_d = 1'b1; end
            if (c == 4) md_use_d = 1'b1;
            if (c == 3) begin
                // count is 3 here; pulse reset between clock edges.
                #2 reset = 1'b1;
                exp_sc = 32'd0;
                push_exp(1'b0, 1'b0);
                #1;
            end else begin
                push_exp(c == 0, (c == 1) || (c == 2));
                @(negedge clk);
            end
            e = sb.pop_front();
            checks++;
            if ({pc_en, fd_en, id_ex_clr, md_busy} !== {e.pc, e.fd, e.clr, e.busy} || stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL reset_mid_count cyc=%0d got pc_en=%b fd_en=%b clr=%b busy=%b sc=%0d want %b %b %b %b %0d",
                         c, pc_en, fd_en, id_ex_clr, md_busy, stall_cycles, e.pc, e.fd, e.clr, e.busy, e.sc);
            end
            if (e.clr && c != 3) exp_sc++;
            next_cycle();
            if (c == 3) reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_zero_reg();
        test_div_stall();
        test_mult_req();
        test_eret();
        test_back_to_back();
        test_reset_mid_count();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
